// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: instruction opcodes, fetch FSM states, fetch entry and reset/halt addresses.
// Pure declarations; no logic or latency of its own.
// Backpressure: not applicable.
package instr_fetch_pkg;

  localparam logic [31:0] IF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] IF_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } instruction_code;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_FULL = 2'd2,
    FETCH_HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Avalon delivers little-endian byte lanes; the core decodes big-endian words.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetched word and its pc when decode is stalled.
// Latency: entry visible the cycle after push.
// Backpressure: owner must not push while full; flush has priority over push and pop.
module fetch_skid_buffer
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         vld,
  output fetch_entry_t entry
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld   <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (push) begin
      vld   <= 1'b1;
      entry <= push_entry;
    end else if (pop) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Avalon-MM instruction fetch with output register + skid slot; INSTR_FETCH_ENDIAN_SWAP_EN byte-swaps captured words.
// Latency: instr_valid one cycle after an accepted read (read && !waitrequest).
// Backpressure: stall holds the output; a second stalled word parks in the skid slot and reads stop until stall drops.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = IF_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_address,
  input  logic        stall,
  input  logic        pc_halt,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic        read,
  output logic [3:0]  byteenable,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        halted
);

  localparam logic [1:0] ST_IDLE = FETCH_IDLE;
  localparam logic [1:0] ST_REQ  = FETCH_REQ;
  localparam logic [1:0] ST_FULL = FETCH_FULL;
  localparam logic [1:0] ST_HALT = FETCH_HALT;

  logic [1:0]   state;
  logic         use_rv;
  logic         hold_vld;
  logic [31:0]  hold_addr;
  logic         in_req;
  logic         accept;
  logic         halt_now;
  logic         consume;
  logic [31:0]  cap_word;
  logic         skid_push;
  logic         skid_pop;
  logic         skid_vld;
  fetch_entry_t skid_entry;
  logic         unused_pc_lsb;

  assign unused_pc_lsb = ^pc_address[1:0];

  assign in_req = (state == ST_REQ);

  // First request after reset goes to the reset vector; a stalled request keeps its latched address.
  assign address = (!in_req || use_rv) ? RESET_VECTOR :
                   hold_vld            ? hold_addr    :
                                         {pc_address[31:2], 2'b00};

  assign read       = in_req && !pc_halt;
  assign byteenable = 4'b1111;
  assign fetch_busy = (in_req && waitrequest) || (state == ST_FULL) || (state == ST_IDLE);
  assign halted     = (state == ST_HALT);

  assign halt_now = pc_halt || (read && !waitrequest && (address == HALT_ADDR));
  assign accept   = read && !waitrequest && (address != HALT_ADDR);
  assign consume  = instr_valid && !stall;

`ifdef INSTR_FETCH_ENDIAN_SWAP_EN
  assign cap_word = swap_bytes(readdata);
`else
  assign cap_word = readdata;
`endif

  assign skid_push = accept && instr_valid && stall;
  assign skid_pop  = (state == ST_FULL) && !stall && !halt_now;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (halt_now),
    .push_entry ('{pc: address, word: cap_word}),
    .vld        (skid_vld),
    .entry      (skid_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      use_rv      <= 1'b1;
      hold_vld    <= 1'b0;
      hold_addr   <= '0;
      instr_valid <= 1'b0;
      instr_word  <= '0;
      instr_pc    <= '0;
    end else if (halt_now) begin
      // Any in-flight read is abandoned; nothing more is presented until reset.
      state       <= ST_HALT;
      hold_vld    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (read && waitrequest) begin
            hold_vld  <= 1'b1;
            hold_addr <= address;
          end
          if (accept) begin
            use_rv   <= 1'b0;
            hold_vld <= 1'b0;
            if (instr_valid && stall) begin
              state <= ST_FULL;
            end else begin
              instr_valid <= 1'b1;
              instr_word  <= cap_word;
              instr_pc    <= address;
            end
          end else if (consume) begin
            instr_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (!stall) begin
            instr_valid <= skid_vld;
            instr_word  <= skid_entry.word;
            instr_pc    <= skid_entry.pc;
            state       <= ST_REQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a queue-based model of the fetch rules.
module tb_instr_fetch;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] HA = 32'h0000_0000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

`ifdef INSTR_FETCH_ENDIAN_SWAP_EN
  localparam logic [31:0] EXP_RV_WORD = 32'h2402_0005;
`else
  localparam logic [31:0] EXP_RV_WORD = 32'h0500_0224;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic        stall;
  logic        pc_halt;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_busy;
  logic        halted;

  int checks = 0;
  int failures = 0;

  // Model: words fetched but not yet consumed, oldest first, as {pc, word}.
  logic [63:0] pend[$];
  int          mode;
  bit          first;
  bit          wait_vld;
  logic [31:0] wait_addr;
  logic [31:0] pc;
  int          jump_pct;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc_address  (pc_address),
    .stall       (stall),
    .pc_halt     (pc_halt),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .address     (address),
    .read        (read),
    .byteenable  (byteenable),
    .instr_word  (instr_word),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fetch_busy  (fetch_busy),
    .halted      (halted)
  );

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == RV) return 32'h0500_0224;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef INSTR_FETCH_ENDIAN_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    pend.delete();
    first = 1'b1;
    wait_vld = 1'b0;
    wait_addr = '0;
    pc = RV;
  endtask

  // One clock: called just after a rising edge, returns just after the next one.
  task automatic step(input bit st, input bit wr, input bit ph);
    logic [31:0] ea;
    bit er, eb, acc;
    stall = st;
    waitrequest = wr;
    pc_halt = ph;
    pc_address = pc | 32'($urandom_range(0, 3));
    if (wait_vld && $urandom_range(0, 1) == 1) pc_address = $urandom;
    er = (mode == M_RUN) && (pend.size() < 2) && !ph;
    eb = (mode == M_IDLE) || ((mode == M_RUN) && ((pend.size() == 2) || wr));
    ea = first ? RV : (wait_vld ? wait_addr : {pc_address[31:2], 2'b00});
    readdata = wr ? $urandom : data_of(ea);

    @(negedge clk);
    chk_eq("status", {read, fetch_busy, halted, instr_valid},
           {er, eb, mode == M_HALT, pend.size() != 0});
    chk_eq("byteenable", byteenable, 4'hF);
    if (er) chk_eq("address", address, ea);
    if (pend.size() != 0) chk_eq("instr", {instr_pc, instr_word}, pend[0]);

    acc = er && !wr;
    if (mode == M_IDLE) begin
      mode = ph ? M_HALT : M_RUN;
    end else if (mode == M_RUN) begin
      if (ph || (acc && ea == HA)) begin
        mode = M_HALT;
        pend.delete();
      end else if (pend.size() == 2) begin
        if (!st) void'(pend.pop_front());
      end else begin
        if (pend.size() != 0 && !st) void'(pend.pop_front());
        if (acc) begin
          pend.push_back({ea, exp_word(data_of(ea))});
          first = 1'b0;
          wait_vld = 1'b0;
        end else if (er && wr && !wait_vld) begin
          wait_vld = 1'b1;
          wait_addr = ea;
        end
      end
    end
    if (!eb) begin
      if ($urandom_range(0, 99) < jump_pct) pc = 32'h0040_0000 + 32'($urandom_range(0, 1023)) * 4;
      else pc = pc + 32'd4;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input int ph_pct);
    step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < ph_pct);
  endtask

  // Asserts reset between edges, checks the asynchronous effect, then releases into the IDLE cycle.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk_eq("arst_status", {read, fetch_busy, halted, instr_valid}, 4'b0100);
    chk_eq("arst_addr", address, RV);
    chk_eq("arst_instr", {instr_pc, instr_word}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    pc_halt = 1'b0;
    waitrequest = 1'b0;
    pc_address = RV;
    readdata = '0;
    jump_pct = 0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_status", {read, fetch_busy, halted, instr_valid}, 4'b0100);
    chk_eq("rst_addr", address, RV);
    chk_eq("rst_instr", {instr_pc, instr_word}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // First fetch from the reset vector.
    step(0, 0, 0);
    step(0, 0, 0);
    #1;
    chk_eq("first_valid", instr_valid, 1'b1);
    chk_eq("first_fetch", {instr_pc, instr_word}, {RV, EXP_RV_WORD});

    // Three wait states, then capture.
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);

    // Stall long enough to fill the skid slot, then drain in order.
    repeat (4) step(1, 0, 0);
    repeat (4) step(0, 0, 0);

    jump_pct = 10;
    repeat (500) rstep(0);

    // Branch to the halt address.
    repeat (3) step(0, 0, 0);
    pc = HA;
    step(0, 0, 0);
    chk_eq("halt_addr", halted, 1'b1);
    repeat (6) rstep(0);
    do_reset();

    // Reset while a read is waiting; fetch must restart at the reset vector.
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    do_reset();
    repeat (4) step(0, 0, 0);

    repeat (4) begin
      repeat (150) rstep(3);
      do_reset();
    end
    repeat (3) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
